// File: rtl/dp_op_sequencer.sv
// Control sequencer for the Phase-1 datapath: preloads registers through the MDR,
// then walks one fetch/execute pass (T0-T6) with registered control outputs.
module dp_op_sequencer #(
  parameter int DATA_W      = 32,
  parameter int MAX_PRELOAD = 3,
  parameter int OP_W        = 4
) (
  input  logic                          clk,
  input  logic                          clr,
  input  logic                          start,
  input  logic [3:0]                    preload_cnt,
  input  logic [DATA_W*MAX_PRELOAD-1:0] preload_data,
  input  logic [4*MAX_PRELOAD-1:0]      preload_dst,
  input  logic [DATA_W-1:0]             instr,
  input  logic [OP_W-1:0]               op,
  input  logic [3:0]                    src_a,
  input  logic [3:0]                    src_b,
  input  logic [3:0]                    dst,
  input  logic                          unary,
  input  logic                          wide,
  output logic [31:0]                   enable,
  output logic [31:0]                   bus_select,
  output logic [DATA_W-1:0]             mdata_in,
  output logic                          md_read,
  output logic [OP_W-1:0]               control_signals,
  output logic                          busy,
  output logic                          done
);

  localparam int         KW      = (MAX_PRELOAD > 1) ? $clog2(MAX_PRELOAD) : 1;
  localparam logic [3:0] MAX_CNT = 4'(MAX_PRELOAD);

  localparam int B_PC   = 20;
  localparam int B_MDR  = 21;
  localparam int B_Y    = 22;
  localparam int B_IR   = 23;
  localparam int B_Z    = 24;
  localparam int B_MAR  = 25;
  localparam int B_ZLO  = 27;
  localparam int B_ZHI  = 28;
  localparam int B_HI   = 29;
  localparam int B_LO   = 30;

  typedef enum logic [3:0] {
    S_IDLE, S_LD_A, S_LD_B, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_DONE
  } state_t;

  state_t state_reg, state_next;
  logic [3:0] k_reg, k_next;
  logic [3:0] cnt_reg, cnt_next;
  logic [DATA_W*MAX_PRELOAD-1:0] data_reg, data_next;
  logic [4*MAX_PRELOAD-1:0] pdst_reg, pdst_next;
  logic [DATA_W-1:0] instr_reg, instr_next;
  logic [OP_W-1:0] op_reg, op_next;
  logic [3:0] src_a_reg, src_a_next;
  logic [3:0] src_b_reg, src_b_next;
  logic [3:0] dst_reg, dst_next;
  logic unary_reg, unary_next;
  logic wide_reg, wide_next;
  logic [3:0] cnt_clamped;

  logic [31:0] enable_next, bus_select_next;
  logic [DATA_W-1:0] mdata_in_next;
  logic md_read_next, busy_next, done_next;
  logic [OP_W-1:0] control_signals_next;

  logic [DATA_W-1:0] word_next [MAX_PRELOAD];
  logic [3:0] wdst_next [MAX_PRELOAD];
  logic [KW-1:0] k_idx;

  // Outputs are computed from the *next* captured values so LD_A/T0 can be valid on the accept edge.
  genvar gi;
  generate
    for (gi = 0; gi < MAX_PRELOAD; gi++) begin : g_unpack
      assign word_next[gi] = data_next[gi*DATA_W +: DATA_W];
      assign wdst_next[gi] = pdst_next[gi*4 +: 4];
    end
  endgenerate

  assign cnt_clamped = (preload_cnt > MAX_CNT) ? MAX_CNT : preload_cnt;
  assign k_idx       = k_next[KW-1:0];

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_reg       <= S_IDLE;
      k_reg           <= '0;
      cnt_reg         <= '0;
      data_reg        <= '0;
      pdst_reg        <= '0;
      instr_reg       <= '0;
      op_reg          <= '0;
      src_a_reg       <= '0;
      src_b_reg       <= '0;
      dst_reg         <= '0;
      unary_reg       <= 1'b0;
      wide_reg        <= 1'b0;
      enable          <= '0;
      bus_select      <= '0;
      mdata_in        <= '0;
      md_read         <= 1'b0;
      control_signals <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      state_reg       <= state_next;
      k_reg           <= k_next;
      cnt_reg         <= cnt_next;
      data_reg        <= data_next;
      pdst_reg        <= pdst_next;
      instr_reg       <= instr_next;
      op_reg          <= op_next;
      src_a_reg       <= src_a_next;
      src_b_reg       <= src_b_next;
      dst_reg         <= dst_next;
      unary_reg       <= unary_next;
      wide_reg        <= wide_next;
      enable          <= enable_next;
      bus_select      <= bus_select_next;
      mdata_in        <= mdata_in_next;
      md_read         <= md_read_next;
      control_signals <= control_signals_next;
      busy            <= busy_next;
      done            <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    k_next     = k_reg;
    cnt_next   = cnt_reg;
    data_next  = data_reg;
    pdst_next  = pdst_reg;
    instr_next = instr_reg;
    op_next    = op_reg;
    src_a_next = src_a_reg;
    src_b_next = src_b_reg;
    dst_next   = dst_reg;
    unary_next = unary_reg;
    wide_next  = wide_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          k_next     = '0;
          cnt_next   = cnt_clamped;
          data_next  = preload_data;
          pdst_next  = preload_dst;
          instr_next = instr;
          op_next    = op;
          src_a_next = src_a;
          src_b_next = src_b;
          dst_next   = dst;
          unary_next = unary;
          wide_next  = wide;
          state_next = (cnt_clamped != 4'd0) ? S_LD_A : S_T0;
        end
      end
      S_LD_A: state_next = S_LD_B;
      S_LD_B: begin
        if ((k_reg + 4'd1) < cnt_reg) begin
          k_next     = k_reg + 4'd1;
          state_next = S_LD_A;
        end else begin
          state_next = S_T0;
        end
      end
      S_T0:    state_next = S_T1;
      S_T1:    state_next = S_T2;
      S_T2:    state_next = unary_reg ? S_T4 : S_T3;
      S_T3:    state_next = S_T4;
      S_T4:    state_next = S_T5;
      S_T5:    state_next = wide_reg ? S_T6 : S_DONE;
      S_T6:    state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    enable_next          = '0;
    bus_select_next      = '0;
    mdata_in_next        = '0;
    md_read_next         = 1'b0;
    control_signals_next = '0;
    busy_next            = (state_next != S_IDLE);
    done_next            = 1'b0;
    case (state_next)
      S_LD_A: begin
        md_read_next       = 1'b1;
        enable_next[B_MDR] = 1'b1;
        mdata_in_next      = word_next[k_idx];
      end
      S_LD_B: begin
        bus_select_next[B_MDR] = 1'b1;
        enable_next            = 32'd1 << wdst_next[k_idx];
      end
      S_T0: begin
        bus_select_next[B_PC] = 1'b1;
        enable_next[B_MAR]    = 1'b1;
        enable_next[B_PC]     = 1'b1;
      end
      S_T1: begin
        md_read_next       = 1'b1;
        enable_next[B_MDR] = 1'b1;
        mdata_in_next      = instr_next;
      end
      S_T2: begin
        bus_select_next[B_MDR] = 1'b1;
        enable_next[B_IR]      = 1'b1;
      end
      S_T3: begin
        bus_select_next  = 32'd1 << src_a_next;
        enable_next[B_Y] = 1'b1;
      end
      S_T4: begin
        bus_select_next      = 32'd1 << (unary_next ? src_a_next : src_b_next);
        enable_next[B_Z]     = 1'b1;
        control_signals_next = op_next;
      end
      S_T5: begin
        bus_select_next[B_ZLO] = 1'b1;
        if (wide_next) enable_next[B_LO] = 1'b1;
        else           enable_next       = 32'd1 << dst_next;
      end
      S_T6: begin
        bus_select_next[B_ZHI] = 1'b1;
        enable_next[B_HI]      = 1'b1;
      end
      S_DONE:  done_next = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dp_op_sequencer.sv
// Bench for dp_op_sequencer: random transactions on a default instance and a
// 16-bit/8-preload instance, checked cycle by cycle against an expected trace.
module tb_dp_op_sequencer;

  logic clk = 1'b0;
  logic clr = 1'b0;
  logic start_a = 1'b0, start_w = 1'b0;
  logic [3:0] preload_cnt = '0;
  logic [95:0] pdata_a = '0;
  logic [11:0] pdst_a = '0;
  logic [127:0] pdata_w = '0;
  logic [31:0] pdst_w = '0;
  logic [31:0] instr = '0;
  logic [3:0] op = '0, src_a = '0, src_b = '0, dst = '0;
  logic unary = 1'b0, wide = 1'b0;

  logic [31:0] en_a, bs_a, md_a;
  logic mr_a, busy_a, done_a;
  logic [3:0] cs_a;
  logic [31:0] en_w, bs_w;
  logic [15:0] md_w;
  logic mr_w, busy_w, done_w;
  logic [3:0] cs_w;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dp_op_sequencer #(.DATA_W(32), .MAX_PRELOAD(3), .OP_W(4)) u_a (
    .clk(clk), .clr(clr), .start(start_a), .preload_cnt(preload_cnt),
    .preload_data(pdata_a), .preload_dst(pdst_a), .instr(instr), .op(op),
    .src_a(src_a), .src_b(src_b), .dst(dst), .unary(unary), .wide(wide),
    .enable(en_a), .bus_select(bs_a), .mdata_in(md_a), .md_read(mr_a),
    .control_signals(cs_a), .busy(busy_a), .done(done_a)
  );

  dp_op_sequencer #(.DATA_W(16), .MAX_PRELOAD(8), .OP_W(4)) u_w (
    .clk(clk), .clr(clr), .start(start_w), .preload_cnt(preload_cnt),
    .preload_data(pdata_w), .preload_dst(pdst_w), .instr(instr[15:0]), .op(op),
    .src_a(src_a), .src_b(src_b), .dst(dst), .unary(unary), .wide(wide),
    .enable(en_w), .bus_select(bs_w), .mdata_in(md_w), .md_read(mr_w),
    .control_signals(cs_w), .busy(busy_w), .done(done_w)
  );

  typedef struct packed {
    logic [31:0] en;
    logic [31:0] bs;
    logic [31:0] md;
    logic        mr;
    logic [3:0]  cs;
    logic        busy;
    logic        done;
  } obs_t;

  obs_t exp_q[$];
  logic [31:0] m_words [8];
  logic [3:0]  m_dsts [8];
  logic [31:0] m_instr;
  logic [3:0]  m_op, m_src_a, m_src_b, m_dst;
  logic        m_unary, m_wide;

  function automatic obs_t mk(input logic [31:0] en, input logic [31:0] bs,
                              input logic [31:0] md, input logic mr,
                              input logic [3:0] cs, input logic dn);
    obs_t o;
    o.en = en; o.bs = bs; o.md = md; o.mr = mr; o.cs = cs; o.busy = 1'b1; o.done = dn;
    return o;
  endfunction

  function automatic obs_t sample(input bit sel);
    obs_t o;
    if (sel) begin
      o.en = en_w; o.bs = bs_w; o.md = {16'h0, md_w}; o.mr = mr_w;
      o.cs = cs_w; o.busy = busy_w; o.done = done_w;
    end else begin
      o.en = en_a; o.bs = bs_a; o.md = md_a; o.mr = mr_a;
      o.cs = cs_a; o.busy = busy_a; o.done = done_a;
    end
    return o;
  endfunction

  function automatic int clamp_cnt(input bit sel, input int cnt_in);
    int maxp;
    maxp = sel ? 8 : 3;
    return (cnt_in > maxp) ? maxp : cnt_in;
  endfunction

  // Expected per-cycle trace, one entry per cycle starting with the cycle after the accept edge.
  task automatic build_expected(input bit sel, input int cnt_in);
    int n;
    logic [31:0] mask;
    obs_t idle;
    idle = '0;
    n = clamp_cnt(sel, cnt_in);
    mask = sel ? 32'h0000_ffff : 32'hffff_ffff;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(mk(32'd1 << 21, 32'd0, m_words[i] & mask, 1'b1, 4'd0, 1'b0));
      exp_q.push_back(mk(32'd1 << m_dsts[i], 32'd1 << 21, 32'd0, 1'b0, 4'd0, 1'b0));
    end
    exp_q.push_back(mk((32'd1 << 25) | (32'd1 << 20), 32'd1 << 20, 32'd0, 1'b0, 4'd0, 1'b0));
    exp_q.push_back(mk(32'd1 << 21, 32'd0, m_instr & mask, 1'b1, 4'd0, 1'b0));
    exp_q.push_back(mk(32'd1 << 23, 32'd1 << 21, 32'd0, 1'b0, 4'd0, 1'b0));
    if (!m_unary)
      exp_q.push_back(mk(32'd1 << 22, 32'd1 << m_src_a, 32'd0, 1'b0, 4'd0, 1'b0));
    exp_q.push_back(mk(32'd1 << 24, 32'd1 << (m_unary ? m_src_a : m_src_b), 32'd0, 1'b0, m_op, 1'b0));
    if (m_wide) begin
      exp_q.push_back(mk(32'd1 << 30, 32'd1 << 27, 32'd0, 1'b0, 4'd0, 1'b0));
      exp_q.push_back(mk(32'd1 << 29, 32'd1 << 28, 32'd0, 1'b0, 4'd0, 1'b0));
    end else begin
      exp_q.push_back(mk(32'd1 << m_dst, 32'd1 << 27, 32'd0, 1'b0, 4'd0, 1'b0));
    end
    exp_q.push_back(mk(32'd0, 32'd0, 32'd0, 1'b0, 4'd0, 1'b1));
    exp_q.push_back(idle);
  endtask

  task automatic randomize_txn();
    for (int i = 0; i < 8; i++) begin
      m_words[i] = $urandom;
      m_dsts[i]  = 4'($urandom_range(0, 15));
    end
    m_instr = $urandom;
    m_op    = 4'($urandom_range(0, 15));
    m_src_a = 4'($urandom_range(0, 15));
    m_src_b = 4'($urandom_range(0, 15));
    m_dst   = 4'($urandom_range(0, 15));
    m_unary = 1'($urandom_range(0, 1));
    m_wide  = 1'($urandom_range(0, 1));
  endtask

  task automatic drive_inputs(input int cnt_in);
    preload_cnt = 4'(cnt_in);
    for (int i = 0; i < 3; i++) begin
      pdata_a[i*32 +: 32] = m_words[i];
      pdst_a[i*4 +: 4]    = m_dsts[i];
    end
    for (int i = 0; i < 8; i++) begin
      pdata_w[i*16 +: 16] = m_words[i][15:0];
      pdst_w[i*4 +: 4]    = m_dsts[i];
    end
    instr = m_instr; op = m_op; src_a = m_src_a; src_b = m_src_b;
    dst = m_dst; unary = m_unary; wide = m_wide;
  endtask

  // Called just after a falling edge; returns at the falling edge where IDLE is first seen.
  task automatic run_seq(input bit sel, input int cnt_in, input int poke_at,
                         input int extra_idle, input string name);
    int len_exp, done_at;
    obs_t o, e, idle;
    idle = '0;
    build_expected(sel, cnt_in);
    for (int i = 0; i < extra_idle; i++) exp_q.push_back(idle);
    len_exp = 2 * clamp_cnt(sel, cnt_in) + 6 - (m_unary ? 1 : 0) + (m_wide ? 1 : 0);
    drive_inputs(cnt_in);
    if (sel) start_w = 1'b1; else start_a = 1'b1;
    @(posedge clk);
    done_at = -1;
    for (int j = 0; j < exp_q.size(); j++) begin
      @(negedge clk);
      o = sample(sel);
      e = exp_q[j];
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s cyc %0d: got en=%h bs=%h md=%h mr=%b cs=%h busy=%b done=%b want en=%h bs=%h md=%h mr=%b cs=%h busy=%b done=%b",
                 name, j, o.en, o.bs, o.md, o.mr, o.cs, o.busy, o.done,
                 e.en, e.bs, e.md, e.mr, e.cs, e.busy, e.done);
      end
      if (o.done === 1'b1 && done_at < 0) done_at = j;
      if (j == poke_at) begin
        if (sel) start_w = 1'b1; else start_a = 1'b1;
        op = ~op;
      end else begin
        start_a = 1'b0;
        start_w = 1'b0;
      end
    end
    checks++;
    if (done_at != len_exp) begin
      errors++;
      $display("FAIL %s length: done at %0d cycles, want %0d", name, done_at, len_exp);
    end
    $display("txn %s sel=%0d cnt=%0d unary=%0d wide=%0d len=%0d", name, sel, cnt_in, m_unary, m_wide, len_exp);
  endtask

  task automatic test_reset();
    obs_t z;
    z = '0;
    #12;
    checks++;
    if (sample(0) !== z) begin errors++; $display("FAIL reset_a: got %h want 0", sample(0)); end
    checks++;
    if (sample(1) !== z) begin errors++; $display("FAIL reset_w: got %h want 0", sample(1)); end
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    checks++;
    if (sample(0) !== z) begin errors++; $display("FAIL reset_idle: got %h want 0", sample(0)); end
  endtask

  task automatic test_neg_phase1();
    randomize_txn();
    m_words[0] = 32'h12; m_dsts[0] = 4'd2;
    m_words[1] = 32'h14; m_dsts[1] = 4'd3;
    m_words[2] = 32'h18; m_dsts[2] = 4'd1;
    m_instr = 32'h9008_0000; m_op = 4'd5; m_unary = 1'b1; m_wide = 1'b0;
    m_src_a = 4'd1; m_dst = 4'd4;
    run_seq(0, 3, -1, 0, "neg_phase1");
  endtask

  task automatic test_binary_wide();
    randomize_txn();
    m_src_a = 4'd2; m_src_b = 4'd3; m_wide = 1'b1; m_unary = 1'b0; m_op = 4'hA;
    run_seq(0, 2, -1, 0, "binary_wide");
  endtask

  task automatic test_zero_preload();
    randomize_txn();
    run_seq(0, 0, -1, 0, "zero_preload");
    randomize_txn();
    run_seq(0, 9, -1, 0, "clamp_9");
  endtask

  task automatic test_start_while_busy();
    int n;
    randomize_txn();
    m_unary = 1'b0;
    n = $urandom_range(0, 3);
    run_seq(0, n, 2 * n + 2, 3, "start_busy");
  endtask

  task automatic test_async_reset();
    obs_t z;
    z = '0;
    randomize_txn();
    drive_inputs(2);
    start_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_a = 1'b0;
    @(negedge clk);
    checks++;
    if (en_a !== (32'd1 << m_dsts[0]) || bs_a !== (32'd1 << 21)) begin
      errors++;
      $display("FAIL pre_reset_ld_b: got en=%h bs=%h want en=%h bs=%h", en_a, bs_a, 32'd1 << m_dsts[0], 32'd1 << 21);
    end
    #2 clr = 1'b0;
    #1;
    checks++;
    if (sample(0) !== z) begin errors++; $display("FAIL async_clear: got %h want 0", sample(0)); end
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    checks++;
    if (sample(0) !== z) begin errors++; $display("FAIL idle_after_release: got %h want 0", sample(0)); end
    randomize_txn();
    run_seq(0, $urandom_range(0, 3), -1, 0, "after_reset");
  endtask

  task automatic test_param_sweep();
    randomize_txn();
    m_unary = 1'b0; m_wide = 1'b0;
    run_seq(1, 8, -1, 0, "sweep_8");
    randomize_txn();
    run_seq(1, 15, -1, 0, "sweep_clamp");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) begin
      randomize_txn();
      run_seq(1'($urandom_range(0, 1)), $urandom_range(0, 15), -1, 0, "b2b");
    end
  endtask

  initial begin
    test_reset();
    test_neg_phase1();
    test_binary_wide();
    test_zero_preload();
    test_start_while_busy();
    test_async_reset();
    test_param_sweep();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, want finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
